// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a combinational result and a registered copy plus valid flag.
// Optional FULL_ADDER_CHAIN_EN adds a chain input that feeds cout_q back as the carry-in.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef FULL_ADDER_CHAIN_EN
  input  logic             chain,
`endif
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_valid
);

  logic             carry_in;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

`ifdef FULL_ADDER_CHAIN_EN
  // Chaining takes the previous word's carry so multi-word sums can be built serially
  assign carry_in = chain ? cout_q : cin;
`else
  assign carry_in = cin;
`endif

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign sum  = s;
  assign cout = c[WIDTH];

  // Result is captured only on in_valid; out_valid marks exactly the cycle after a capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum_q     <= sum;
      cout_q    <= cout;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: WIDTH=1 truth table, WIDTH=8 wrap vectors, registered stage,
// async reset, and chain mode when FULL_ADDER_CHAIN_EN is defined.
module tb_full_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       inValid;

  logic       a1, b1, cin1;
  logic       sum1, cout1, sumQ1, coutQ1, outValid1;

  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] sum8, sumQ8;
  logic       cout8, coutQ8, outValid8;
`ifdef FULL_ADDER_CHAIN_EN
  logic       chain8;
`endif

  int checks = 0;
  int errors = 0;

  vec_t wideVecs[8];

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
`ifdef FULL_ADDER_CHAIN_EN
    .chain(1'b0),
`endif
    .in_valid(inValid), .sum(sum1), .cout(cout1),
    .sum_q(sumQ1), .cout_q(coutQ1), .out_valid(outValid1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
`ifdef FULL_ADDER_CHAIN_EN
    .chain(chain8),
`endif
    .in_valid(inValid), .sum(sum8), .cout(cout8),
    .sum_q(sumQ8), .cout_q(coutQ8), .out_valid(outValid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #90000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin);
    a8   = a;
    b8   = b;
    cin8 = cin;
  endtask

  initial begin
    logic [2:0] tt;
    logic [1:0] ttExp [8];
    ttExp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    wideVecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    wideVecs[1] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
    wideVecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    wideVecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    wideVecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    wideVecs[5] = '{8'h0F, 8'h01, 1'b1, 8'h11, 1'b0};
    wideVecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    wideVecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    rst     = 1'b1;
    inValid = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
`ifdef FULL_ADDER_CHAIN_EN
    chain8 = 1'b0;
`endif
    applyStimulus(8'h00, 8'h00, 1'b0);
    #1;
    checkOutput("reset sum_q", {56'd0, sumQ8}, 64'd0);
    checkOutput("reset cout_q", {63'd0, coutQ8}, 64'd0);
    checkOutput("reset out_valid", {63'd0, outValid8}, 64'd0);

    // Combinational checks run while rst is held to show the adder ignores it
    for (int i = 0; i < 8; i++) begin
      tt = 3'(i);
      {a1, b1, cin1} = tt;
      #10;
      checkOutput($sformatf("truth table %0d", i), {62'd0, cout1, sum1}, {62'd0, ttExp[i]});
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(wideVecs[i].a, wideVecs[i].b, wideVecs[i].cin);
      #10;
      checkOutput($sformatf("wide vec %0d", i), {55'd0, cout8, sum8},
                  {55'd0, wideVecs[i].cout, wideVecs[i].sum});
    end

    @(negedge clk);
    rst = 1'b0;

    // Single capture, then a hold cycle
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    applyStimulus(8'h7F, 8'h80, 1'b1);
    inValid = 1'b1;
    @(posedge clk); #1;
    checkOutput("capture sum_q", {63'd0, sumQ1}, 64'd1);
    checkOutput("capture cout_q", {63'd0, coutQ1}, 64'd1);
    checkOutput("capture out_valid", {63'd0, outValid1}, 64'd1);
    checkOutput("capture wide", {55'd0, coutQ8, sumQ8}, {55'd0, 1'b1, 8'h00});

    @(negedge clk);
    inValid = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    checkOutput("hold out_valid", {63'd0, outValid1}, 64'd0);
    checkOutput("hold sum_q", {63'd0, sumQ1}, 64'd1);
    checkOutput("hold cout_q", {63'd0, coutQ1}, 64'd1);
    checkOutput("hold wide", {55'd0, coutQ8, sumQ8}, {55'd0, 1'b1, 8'h00});

    // A pulse on in_valid between edges must not be captured
    #2 inValid = 1'b1;
    #2 inValid = 1'b0;
    @(posedge clk); #1;
    checkOutput("glitch out_valid", {63'd0, outValid1}, 64'd0);
    checkOutput("glitch wide hold", {55'd0, coutQ8, sumQ8}, {55'd0, 1'b1, 8'h00});

    // Async reset mid-cycle with valid data in the register
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    inValid = 1'b1;
    @(posedge clk); #1;
    checkOutput("pre-reset out_valid", {63'd0, outValid1}, 64'd1);
    checkOutput("pre-reset sum_q", {63'd0, sumQ1}, 64'd1);
    checkOutput("pre-reset cout_q", {63'd0, coutQ1}, 64'd0);
    #2;
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    #1;
    checkOutput("async sum_q", {63'd0, sumQ1}, 64'd0);
    checkOutput("async cout_q", {63'd0, coutQ1}, 64'd0);
    checkOutput("async out_valid", {63'd0, outValid1}, 64'd0);
    checkOutput("async wide sum_q", {56'd0, sumQ8}, 64'd0);
    checkOutput("comb during reset", {62'd0, cout1, sum1}, {62'd0, 2'b10});
    @(posedge clk); #1;
    checkOutput("reset held out_valid", {63'd0, outValid1}, 64'd0);
    checkOutput("reset held sum_q", {63'd0, sumQ1}, 64'd0);

    @(negedge clk);
    rst = 1'b0;
    inValid = 1'b0;

`ifdef FULL_ADDER_CHAIN_EN
    // First chained word after reset must see carry 0, not cin
    @(negedge clk);
    chain8 = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b1);
    inValid = 1'b1;
    @(posedge clk); #1;
    checkOutput("chain first word", {55'd0, coutQ8, sumQ8}, {55'd0, 1'b0, 8'h00});

    @(negedge clk);
    chain8 = 1'b0;
    applyStimulus(8'hFF, 8'h01, 1'b0);
    @(posedge clk); #1;
    checkOutput("chain cycle 1", {55'd0, coutQ8, sumQ8}, {55'd0, 1'b1, 8'h00});

    @(negedge clk);
    chain8 = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b0);
    #1;
    checkOutput("chain comb", {55'd0, cout8, sum8}, {55'd0, 1'b0, 8'h01});
    @(posedge clk); #1;
    checkOutput("chain cycle 2", {55'd0, coutQ8, sumQ8}, {55'd0, 1'b0, 8'h01});

    @(negedge clk);
    inValid = 1'b0;
    chain8 = 1'b0;
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

- Single-bit (default) or WIDTH-bit ripple-carry full adder.
- Produces combinational sum/carry in the same delta cycle as its inputs.
- Also provides a registered copy of the result with a valid flag.
- Leaf arithmetic cell of the datapath: the ALU and lane adders instantiate it directly, and pipeline stages consume the registered outputs.

## Interface

Parameters:
- WIDTH, 1, operand and sum width in bits (legal 1..64).

Ports:
- clk  input  1  rising-edge clock; used only by the registered output stage.
- rst  input  1  reset, asynchronous, active-high; clears the registered output stage.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  combinational sum, (a + b + cin) mod 2^WIDTH.
- cout  output  1  combinational carry out of bit WIDTH-1.
- in_valid  input  1  capture enable for the registered stage.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry.
- out_valid  output  1  registered qualifier for sum_q/cout_q.
- chain  input  1  present only with FULL_ADDER_CHAIN_EN; selects the registered carry as carry-in.

## Operation

- Bit cell: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])); c[0] = effective carry-in.
- Effective carry-in is cin (or cout_q when chaining is active; see Configuration). sum = s[WIDTH-1:0], cout = c[WIDTH].
- Full {cout, sum} equals a + b + cin as a (WIDTH+1)-bit unsigned value. No saturation; wrap-around is mod 2^WIDTH with the carry in cout.
- The combinational path does not depend on clk, rst or in_valid. It must produce correct outputs with clk and rst left undriven.
- Registered stage, on rising clk:
  - in_valid=1: sum_q <= sum, cout_q <= cout, out_valid <= 1.
  - in_valid=0: sum_q and cout_q hold; out_valid <= 0.
- No handshake back-pressure; every in_valid cycle is accepted.

## Timing

- sum/cout: zero-cycle latency, purely combinational from a, b, cin (and chain/cout_q when enabled).
- sum_q/cout_q/out_valid: one-cycle latency after the edge that samples in_valid=1.
- Reset values: sum_q = 0, cout_q = 0, out_valid = 0. These apply immediately on rst rising, independent of clk, and hold while rst=1.
- Reset mid-operation: the registered stage clears at once. Combinational sum/cout continue to track the inputs throughout reset.
- in_valid sampled only at rising clk; glitches between edges have no effect.

## Configuration

- FULL_ADDER_CHAIN_EN defined:
  - The chain port exists.
  - When chain=1, effective carry-in = cout_q instead of cin, for both the combinational and registered paths. This enables multi-word serial addition across consecutive in_valid cycles.
  - When chain=0, cin is used.
  - After reset, cout_q = 0, so the first chained word adds carry 0.
- FULL_ADDER_CHAIN_EN undefined:
  - The chain port is absent.
  - Effective carry-in is always cin. Behaviour is a plain full adder plus output register.
- Default build: undefined.

## Test plan

- Exhaustive truth table, WIDTH=1, clk/rst undriven; step {a,b,cin} through 000..111 every 10 time units. Required {cout,sum}: 00, 01, 01, 10, 01, 10, 10, 11.
- Registered stage: rst=1 then 0; a=1, b=1, cin=1, in_valid=1 for one edge. After that edge: sum_q=1, cout_q=1, out_valid=1. Next edge with in_valid=0: out_valid=0, sum_q/cout_q hold.
- Async reset mid-operation: with out_valid=1 and sum_q=1, raise rst between clock edges. sum_q, cout_q and out_valid go to 0 before the next edge; sum/cout still follow the inputs.
- Wide wrap, WIDTH=8: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'h7F, b=8'h80, cin=1 -> sum=8'h00, cout=1.
- Chain mode (FULL_ADDER_CHAIN_EN, WIDTH=8):
  - Cycle 1: chain=0, a=8'hFF, b=8'h01, in_valid=1 -> sum_q=8'h00, cout_q=1.
  - Cycle 2: chain=1, a=8'h00, b=8'h00, in_valid=1 -> sum_q=8'h01, cout_q=0.
